// File: rtl/ctrl_pkg.sv
// Shared encodings for the CPU control FSM: opcodes, ALU codes, mux selects,
// FSM state and instruction class enums, and the per-class control vector.
package ctrl_pkg;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ANDI  = 4'b0001;
  localparam logic [3:0] OP_ORI   = 4'b0010;
  localparam logic [3:0] OP_XORI  = 4'b0011;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_LSH   = 4'b1000;
  localparam logic [3:0] OP_SUBI  = 4'b1001;
  localparam logic [3:0] OP_CMPI  = 4'b1011;
  localparam logic [3:0] OP_BCOND = 4'b1100;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_LUI   = 4'b1111;

  localparam logic [3:0] EXT_AND   = 4'b0001;
  localparam logic [3:0] EXT_OR    = 4'b0010;
  localparam logic [3:0] EXT_XOR   = 4'b0011;
  localparam logic [3:0] EXT_ADD   = 4'b0101;
  localparam logic [3:0] EXT_SUB   = 4'b1001;
  localparam logic [3:0] EXT_CMP   = 4'b1011;
  localparam logic [3:0] EXT_MOV   = 4'b1101;
  localparam logic [3:0] EXT_MUL   = 4'b1110;
  localparam logic [3:0] EXT_LSH   = 4'b0100;
  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd5;
  localparam logic [3:0] ALU_LSH = 4'd6;
  localparam logic [3:0] ALU_ASH = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;

  localparam logic [1:0] PC_PLUS1    = 2'b00;
  localparam logic [1:0] PC_PLUS_IMM = 2'b01;
  localparam logic [1:0] PC_RSRC     = 2'b10;

  localparam logic [1:0] SX_SIGN = 2'b00;
  localparam logic [1:0] SX_ZERO = 2'b01;
  localparam logic [1:0] SX_LUI  = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_MEM  = 2'b01;
  localparam logic [1:0] WB_RSRC = 2'b10;
  localparam logic [1:0] WB_IMM  = 2'b11;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEM_RD, ST_LOAD_WB, ST_PC_INC
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU, CLS_BRANCH, CLS_JUMP, CLS_LOAD, CLS_STOR, CLS_NOP
  } instr_class_t;

  // Controls that only matter for single-cycle ALU-class instructions
  typedef struct packed {
    logic       wr_en;
    logic [3:0] alu_sel;
    logic       alu_src;
    logic [1:0] write_back_sel;
    logic [1:0] sign_ext_mode;
    logic       cmp_f_en;
    logic       of_f_en;
    logic       z_f_en;
  } exec_ctrl_t;

  // Full output set of the controller, so it can be cleared in one go
  typedef struct packed {
    logic       wr_en;
    logic [3:0] alu_sel;
    logic       alu_src;
    logic [1:0] write_back_sel;
    logic       pc_en;
    logic       next_instr;
    logic       instr_en;
    logic [1:0] pc_addr_mode;
    logic [1:0] sign_ext_mode;
    logic       cmp_f_en;
    logic       of_f_en;
    logic       z_f_en;
    logic       mem_wr_en;
  } ctrl_out_t;

  // AND/OR/XOR share the codes 1/2/3 as R-type ext and as I-type opcode
  function automatic logic [3:0] logic_alu_sel(input logic [3:0] code);
    return code + 4'd1;
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Control bus between the CPU controller (master) and the DataPath (slave).
interface cpu_controller_if;
  logic [3:0] opcode;
  logic [3:0] opcode_ext;
  logic       cmp_result;
  logic       wr_en;
  logic [3:0] alu_sel;
  logic       alu_src;
  logic [1:0] write_back_sel;
  logic       pc_en;
  logic       next_instr;
  logic       instr_en;
  logic [1:0] pc_addr_mode;
  logic [1:0] sign_ext_mode;
  logic       cmp_f_en;
  logic       of_f_en;
  logic       z_f_en;
  logic       mem_wr_en;

  modport master (
    input  opcode, opcode_ext, cmp_result,
    output wr_en, alu_sel, alu_src, write_back_sel, pc_en, next_instr, instr_en,
           pc_addr_mode, sign_ext_mode, cmp_f_en, of_f_en, z_f_en, mem_wr_en
  );

  modport slave (
    output opcode, opcode_ext, cmp_result,
    input  wr_en, alu_sel, alu_src, write_back_sel, pc_en, next_instr, instr_en,
           pc_addr_mode, sign_ext_mode, cmp_f_en, of_f_en, z_f_en, mem_wr_en
  );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational instruction decoder: opcode/opcode_ext -> instruction class
// plus the ALU-class control vector. Unknown encodings decode as NOP.
module instr_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0]   opcode,
  input  logic [3:0]   opcode_ext,
  output instr_class_t instr_class,
  output exec_ctrl_t   ctrl
);

  // Class and control vector lookup
  always_comb begin
    instr_class = CLS_NOP;
    ctrl        = '0;
    case (opcode)
      OP_RTYPE: begin
        instr_class = CLS_ALU;
        case (opcode_ext)
          EXT_ADD, EXT_SUB: begin
            ctrl.wr_en   = 1'b1;
            ctrl.alu_sel = (opcode_ext == EXT_SUB) ? ALU_SUB : ALU_ADD;
            ctrl.of_f_en = 1'b1;
            ctrl.z_f_en  = 1'b1;
          end
          EXT_AND, EXT_OR, EXT_XOR: begin
            ctrl.wr_en   = 1'b1;
            ctrl.alu_sel = logic_alu_sel(opcode_ext);
            ctrl.z_f_en  = 1'b1;
          end
          EXT_MOV: begin
            ctrl.wr_en          = 1'b1;
            ctrl.write_back_sel = WB_RSRC;
          end
          EXT_MUL: begin
            ctrl.wr_en   = 1'b1;
            ctrl.alu_sel = ALU_MUL;
          end
          EXT_CMP: begin
            ctrl.alu_sel  = ALU_SUB;
            ctrl.cmp_f_en = 1'b1;
            ctrl.z_f_en   = 1'b1;
          end
          default: instr_class = CLS_NOP;
        endcase
      end
      OP_ADDI, OP_SUBI: begin
        instr_class  = CLS_ALU;
        ctrl.wr_en   = 1'b1;
        ctrl.alu_src = 1'b1;
        ctrl.alu_sel = (opcode == OP_SUBI) ? ALU_SUB : ALU_ADD;
        ctrl.of_f_en = 1'b1;
        ctrl.z_f_en  = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        instr_class        = CLS_ALU;
        ctrl.wr_en         = 1'b1;
        ctrl.alu_src       = 1'b1;
        ctrl.alu_sel       = logic_alu_sel(opcode);
        ctrl.sign_ext_mode = SX_ZERO;
        ctrl.z_f_en        = 1'b1;
      end
      OP_MOVI, OP_LUI: begin
        instr_class         = CLS_ALU;
        ctrl.wr_en          = 1'b1;
        ctrl.alu_src        = 1'b1;
        ctrl.write_back_sel = WB_IMM;
        ctrl.sign_ext_mode  = (opcode == OP_LUI) ? SX_LUI : SX_ZERO;
      end
      OP_CMPI: begin
        instr_class   = CLS_ALU;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_sel  = ALU_SUB;
        ctrl.cmp_f_en = 1'b1;
        ctrl.z_f_en   = 1'b1;
      end
      OP_LSH: begin
        if (opcode_ext == EXT_LSH) begin
          instr_class  = CLS_ALU;
          ctrl.wr_en   = 1'b1;
          ctrl.alu_sel = ALU_LSH;
        end
      end
      OP_BCOND: instr_class = CLS_BRANCH;
      OP_MEM: begin
        case (opcode_ext)
          EXT_LOAD:  instr_class = CLS_LOAD;
          EXT_STOR:  instr_class = CLS_STOR;
          EXT_JCOND: instr_class = CLS_JUMP;
          default:   instr_class = CLS_NOP;
        endcase
      end
      default: instr_class = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM driving the DataPath and the BRAM write strobe.
// Optional build macro CTRL_MEM_STALL_EN adds a mem_ready input that stalls
// DECODE, LOAD_WB and the STOR write until the memory reports ready.
//
// state      | meaning
// FETCH      | PC drives BRAM address, read in flight
// DECODE     | instruction word valid, load instruction register
// EXECUTE    | issue class-specific controls, ALU/branch retire here
// MEM_RD     | BRAM address = Rsrc for a LOAD
// LOAD_WB    | write load data to Rdest, advance PC
// PC_INC     | advance PC after a STOR
module cpu_controller
  import ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
`ifdef CTRL_MEM_STALL_EN
  input  logic mem_ready,
`endif
  cpu_controller_if.master bus
);

  state_t       state;
  state_t       state_next;
  instr_class_t instr_class;
  exec_ctrl_t   ctrl;
  ctrl_out_t    out;
  logic         ready;

`ifdef CTRL_MEM_STALL_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  instr_decoder u_decoder (
    .opcode      (bus.opcode),
    .opcode_ext  (bus.opcode_ext),
    .instr_class (instr_class),
    .ctrl        (ctrl)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_FETCH;
    else          state <= state_next;
  end

  // Next state and output decode; all outputs held low while in reset
  always_comb begin
    state_next = state;
    out        = '0;
    case (state)
      ST_FETCH: begin
        out.next_instr = 1'b1;
        state_next     = ST_DECODE;
      end
      ST_DECODE: begin
        out.next_instr = 1'b1;
        if (ready) begin
          out.instr_en = 1'b1;
          state_next   = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (instr_class)
          CLS_ALU: begin
            out.wr_en          = ctrl.wr_en;
            out.alu_sel        = ctrl.alu_sel;
            out.alu_src        = ctrl.alu_src;
            out.write_back_sel = ctrl.write_back_sel;
            out.sign_ext_mode  = ctrl.sign_ext_mode;
            out.cmp_f_en       = ctrl.cmp_f_en;
            out.of_f_en        = ctrl.of_f_en;
            out.z_f_en         = ctrl.z_f_en;
            out.pc_en          = 1'b1;
            state_next         = ST_FETCH;
          end
          CLS_BRANCH: begin
            out.pc_en         = 1'b1;
            out.pc_addr_mode  = bus.cmp_result ? PC_PLUS_IMM : PC_PLUS1;
            out.sign_ext_mode = SX_SIGN;
            state_next        = ST_FETCH;
          end
          CLS_JUMP: begin
            out.pc_en        = 1'b1;
            out.pc_addr_mode = bus.cmp_result ? PC_RSRC : PC_PLUS1;
            state_next       = ST_FETCH;
          end
          CLS_LOAD: state_next = ST_MEM_RD;
          CLS_STOR: begin
            out.mem_wr_en = 1'b1;
            if (ready) state_next = ST_PC_INC;
          end
          default: begin
            out.pc_en  = 1'b1;
            state_next = ST_FETCH;
          end
        endcase
      end
      ST_MEM_RD: state_next = ST_LOAD_WB;
      ST_LOAD_WB: begin
        if (ready) begin
          out.wr_en          = 1'b1;
          out.write_back_sel = WB_MEM;
          out.pc_en          = 1'b1;
          state_next         = ST_FETCH;
        end
      end
      ST_PC_INC: begin
        out.pc_en  = 1'b1;
        state_next = ST_FETCH;
      end
      default: state_next = ST_FETCH;
    endcase
    if (!reset_n) out = '0;
  end

  assign bus.wr_en          = out.wr_en;
  assign bus.alu_sel        = out.alu_sel;
  assign bus.alu_src        = out.alu_src;
  assign bus.write_back_sel = out.write_back_sel;
  assign bus.pc_en          = out.pc_en;
  assign bus.next_instr     = out.next_instr;
  assign bus.instr_en       = out.instr_en;
  assign bus.pc_addr_mode   = out.pc_addr_mode;
  assign bus.sign_ext_mode  = out.sign_ext_mode;
  assign bus.cmp_f_en       = out.cmp_f_en;
  assign bus.of_f_en        = out.of_f_en;
  assign bus.z_f_en         = out.z_f_en;
  assign bus.mem_wr_en      = out.mem_wr_en;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed testbench for cpu_controller. Outputs are packed into one vector
// {wr,alu,src,wb,pc_en,next_instr,instr_en,pc_mode,ext,cmp,of,z,mem_wr}.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic reset_n;
`ifdef CTRL_MEM_STALL_EN
  logic mem_ready;
`endif

  cpu_controller_if bus ();

  cpu_controller dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef CTRL_MEM_STALL_EN
    .mem_ready (mem_ready),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [18:0] obs;
  assign obs = {bus.wr_en, bus.alu_sel, bus.alu_src, bus.write_back_sel, bus.pc_en,
                bus.next_instr, bus.instr_en, bus.pc_addr_mode, bus.sign_ext_mode,
                bus.cmp_f_en, bus.of_f_en, bus.z_f_en, bus.mem_wr_en};

  function automatic logic [18:0] vec(input int wr, input int alu, input int src, input int wb,
                                      input int pc, input int ni, input int ie, input int pm,
                                      input int sx, input int c, input int o, input int z,
                                      input int mw);
    return {wr[0], alu[3:0], src[0], wb[1:0], pc[0], ni[0], ie[0], pm[1:0], sx[1:0],
            c[0], o[0], z[0], mw[0]};
  endfunction

  logic [18:0] v_zero, v_fetch, v_decode, v_pc;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [15:0] instr, input logic cmp);
    bus.opcode     = instr[15:12];
    bus.opcode_ext = instr[7:4];
    bus.cmp_result = cmp;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_instr(16'h0000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== v_zero) begin
      miscompares++;
      $display("FAIL reset_hold: got %b expected %b", obs, v_zero);
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if (obs !== v_fetch) begin
      miscompares++;
      $display("FAIL reset_release_fetch: got %b expected %b", obs, v_fetch);
    end
    #(8);
    step();
    vectors++;
    if (obs !== v_decode) begin
      miscompares++;
      $display("FAIL reset_first_decode: got %b expected %b", obs, v_decode);
    end
    step();
    vectors++;
    if (obs !== v_pc) begin
      miscompares++;
      $display("FAIL reset_nop_execute: got %b expected %b", obs, v_pc);
    end
    step();
  endtask

  task automatic test_add();
    logic [18:0] seq[4];
    seq = '{v_fetch, v_decode, vec(1,0,0,0,1,0,0,0,0,0,1,1,0), v_fetch};
    set_instr(16'h0253, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step();
      vectors++;
      if (obs !== seq[i]) begin
        miscompares++;
        $display("FAIL add[%0d]: got %b expected %b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_alu_table();
    logic [15:0] instrs[18];
    logic [18:0] execs[18];
    instrs = '{16'h0293, 16'h0213, 16'h0223, 16'h0233, 16'h02D3, 16'h02E3, 16'h02B3,
               16'h5207, 16'h9207, 16'h1207, 16'h2207, 16'h3207, 16'hD2FF, 16'hF212,
               16'h8243, 16'h0273, 16'h8203, 16'h7000};
    execs  = '{vec(1,1,0,0,1,0,0,0,0,0,1,1,0),   // SUB
               vec(1,2,0,0,1,0,0,0,0,0,0,1,0),   // AND
               vec(1,3,0,0,1,0,0,0,0,0,0,1,0),   // OR
               vec(1,4,0,0,1,0,0,0,0,0,0,1,0),   // XOR
               vec(1,0,0,2,1,0,0,0,0,0,0,0,0),   // MOV
               vec(1,8,0,0,1,0,0,0,0,0,0,0,0),   // MUL
               vec(0,1,0,0,1,0,0,0,0,1,0,1,0),   // CMP
               vec(1,0,1,0,1,0,0,0,0,0,1,1,0),   // ADDI
               vec(1,1,1,0,1,0,0,0,0,0,1,1,0),   // SUBI
               vec(1,2,1,0,1,0,0,0,1,0,0,1,0),   // ANDI
               vec(1,3,1,0,1,0,0,0,1,0,0,1,0),   // ORI
               vec(1,4,1,0,1,0,0,0,1,0,0,1,0),   // XORI
               vec(1,0,1,3,1,0,0,0,1,0,0,0,0),   // MOVI
               vec(1,0,1,3,1,0,0,0,2,0,0,0,0),   // LUI
               vec(1,6,0,0,1,0,0,0,0,0,0,0,0),   // LSH
               v_pc, v_pc, v_pc};                // undefined encodings
    for (int i = 0; i < 18; i++) begin
      set_instr(instrs[i], 1'b1);
      step();
      step();
      vectors++;
      if (obs !== execs[i]) begin
        miscompares++;
        $display("FAIL alu_exec[%h]: got %b expected %b", instrs[i], obs, execs[i]);
      end
      step();
      vectors++;
      if (obs !== v_fetch) begin
        miscompares++;
        $display("FAIL alu_refetch[%h]: got %b expected %b", instrs[i], obs, v_fetch);
      end
    end
  endtask

  task automatic test_cmpi();
    logic [18:0] exp_v;
    exp_v = vec(0,1,1,0,1,0,0,0,0,1,0,1,0);
    set_instr(16'hB3FC, 1'b0);
    step();
    step();
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL cmpi_exec: got %b expected %b", obs, exp_v);
    end
    step();
  endtask

  task automatic test_load();
    logic [18:0] seq[6];
    seq = '{v_fetch, v_decode, v_zero, v_zero, vec(1,0,0,1,1,0,0,0,0,0,0,0,0), v_fetch};
    set_instr(16'h4800, 1'b0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      vectors++;
      if (obs !== seq[i]) begin
        miscompares++;
        $display("FAIL load[%0d]: got %b expected %b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_stor();
    logic [18:0] seq[5];
    seq = '{v_fetch, v_decode, vec(0,0,0,0,0,0,0,0,0,0,0,0,1), v_pc, v_fetch};
    set_instr(16'h4340, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      vectors++;
      if (obs !== seq[i]) begin
        miscompares++;
        $display("FAIL stor[%0d]: got %b expected %b", i, obs, seq[i]);
      end
    end
  endtask

  task automatic test_branch();
    logic [15:0] instrs[4];
    logic        cmps[4];
    logic [18:0] execs[4];
    instrs = '{16'hC008, 16'hC008, 16'h42C5, 16'h42C5};
    cmps   = '{1'b1, 1'b0, 1'b1, 1'b0};
    execs  = '{vec(0,0,0,0,1,0,0,1,0,0,0,0,0), v_pc,
               vec(0,0,0,0,1,0,0,2,0,0,0,0,0), v_pc};
    for (int i = 0; i < 4; i++) begin
      set_instr(instrs[i], cmps[i]);
      step();
      step();
      vectors++;
      if (obs !== execs[i]) begin
        miscompares++;
        $display("FAIL branch[%0d]: got %b expected %b", i, obs, execs[i]);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_stor();
    set_instr(16'h4340, 1'b0);
    step();
    step();
    vectors++;
    if (obs !== vec(0,0,0,0,0,0,0,0,0,0,0,0,1)) begin
      miscompares++;
      $display("FAIL midrst_stor_exec: got %b expected mem_wr only", obs);
    end
    #1;
    reset_n = 1'b0;
    #1;
    vectors++;
    if (obs !== v_zero) begin
      miscompares++;
      $display("FAIL midrst_forced_zero: got %b expected %b", obs, v_zero);
    end
    set_instr(16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (bus.mem_wr_en !== 1'b0 || bus.wr_en !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_no_write[%0d]: got mem_wr=%b wr=%b expected 0 0", i, bus.mem_wr_en, bus.wr_en);
      end
    end
    reset_n = 1'b1;
    #1;
    vectors++;
    if (obs !== v_fetch) begin
      miscompares++;
      $display("FAIL midrst_release_fetch: got %b expected %b", obs, v_fetch);
    end
    step();
    vectors++;
    if (obs !== v_decode) begin
      miscompares++;
      $display("FAIL midrst_decode: got %b expected %b", obs, v_decode);
    end
    step();
    step();
  endtask

`ifdef CTRL_MEM_STALL_EN
  task automatic test_stall();
    set_instr(16'h0253, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (obs !== v_fetch) begin
        miscompares++;
        $display("FAIL stall_decode_hold[%0d]: got %b expected %b", i, obs, v_fetch);
      end
    end
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (obs !== v_decode) begin
      miscompares++;
      $display("FAIL stall_decode_ready: got %b expected %b", obs, v_decode);
    end
    step();
    vectors++;
    if (obs !== vec(1,0,0,0,1,0,0,0,0,0,1,1,0)) begin
      miscompares++;
      $display("FAIL stall_execute: got %b expected add vector", obs);
    end
    step();
  endtask
`endif

  initial begin
    v_zero   = vec(0,0,0,0,0,0,0,0,0,0,0,0,0);
    v_fetch  = vec(0,0,0,0,0,1,0,0,0,0,0,0,0);
    v_decode = vec(0,0,0,0,0,1,1,0,0,0,0,0,0);
    v_pc     = vec(0,0,0,0,1,0,0,0,0,0,0,0,0);
`ifdef CTRL_MEM_STALL_EN
    mem_ready = 1'b1;
`endif
    test_reset();
    test_add();
    test_alu_table();
    test_cmpi();
    test_load();
    test_stor();
    test_branch();
    test_reset_mid_stor();
`ifdef CTRL_MEM_STALL_EN
    test_stall();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
